// File: rtl/chacha_pkg.sv
// Shared types for the ChaCha20 keystream path: core word/block types,
// block geometry, sequencer state encoding and a little-endian byte picker.
package chacha_pkg;

  localparam int unsigned WORD_W      = 32;
  localparam int unsigned BLOCK_WORDS = 16;
  localparam int unsigned BLOCK_BYTES = 64;
  localparam int unsigned IDX_W       = 6;

  typedef logic [WORD_W-1:0] word_t;
  typedef word_t [BLOCK_WORDS-1:0] block_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_STREAM,
    ST_FIN
  } state_e;

  // Byte k of a block, little-endian within each word (RFC 8439 order).
  function automatic logic [7:0] block_byte(input block_t blk, input logic [IDX_W-1:0] k);
    word_t w;
    w = blk[k[5:2]];
    return w[{k[1:0], 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/block_byte_buffer.sv
// One 64-byte keystream block register with a load port (from the core) and a
// swap port (from the sibling buffer), plus a byte-select read mux.
// Ports: clk/rst (sync, active-high); load/load_data; swap/swap_data;
//        sel (6-bit byte index); words (registered contents); sel_byte_c.
module block_byte_buffer
  import chacha_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  block_t           load_data,
  input  logic             swap,
  input  block_t           swap_data,
  input  logic [IDX_W-1:0] sel,
  output block_t           words,
  output logic [7:0]       sel_byte_c
);

  block_t words_q, words_d;

  // Fresh core data takes priority over a swap.
  always_comb begin
    words_d = words_q;
    if (load) begin
      words_d = load_data;
    end else if (swap) begin
      words_d = swap_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      words_q <= '0;
    end else begin
      words_q <= words_d;
    end
  end

  assign words      = words_q;
  assign sel_byte_c = block_byte(words_q, sel);

endmodule

// File: rtl/keystream_sequencer.sv
// Drives the ChaCha20 block core one 64-byte block at a time and streams the
// keystream out as bytes, prefetching the next block while the current one
// drains so the byte stream has no bubble at block boundaries.
// Ports: clk, rst (sync, active-high); start/msg_len/init_ctr (message setup);
//        core_start/core_ctr -> core, core_done/core_block <- core;
//        ks_byte/ks_valid/ks_last with ks_ready (byte stream);
//        busy, done (end pulse), err_wrap (sticky counter overflow).
module keystream_sequencer
  import chacha_pkg::*;
#(
  parameter int unsigned LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] msg_len,
  input  logic [31:0]      init_ctr,
  output logic             core_start,
  output logic [31:0]      core_ctr,
  input  logic             core_done,
  input  block_t           core_block,
  output logic [7:0]       ks_byte,
  output logic             ks_valid,
  input  logic             ks_ready,
  output logic             ks_last,
  output logic             busy,
  output logic             done,
  output logic             err_wrap
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_BYTES - 1);

  state_e           state_q, state_d;
  logic             core_start_q, core_start_d;
  logic [31:0]      core_ctr_q, core_ctr_d;
  logic [7:0]       ks_byte_q, ks_byte_d;
  logic             ks_valid_q, ks_valid_d;
  logic             ks_last_q, ks_last_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_wrap_q, err_wrap_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             pend_q, pend_d;
  logic             next_valid_q, next_valid_d;

  logic             cur_load, cur_swap, nxt_load;
  block_t           cur_words, nxt_words;
  logic [7:0]       cur_byte_c, nxt_byte0_c;

  block_byte_buffer u_cur (
    .clk       (clk),
    .rst       (rst),
    .load      (cur_load),
    .load_data (core_block),
    .swap      (cur_swap),
    .swap_data (nxt_words),
    .sel       (IDX_W'(idx_q + 1'b1)),
    .words     (cur_words),
    .sel_byte_c(cur_byte_c)
  );

  block_byte_buffer u_nxt (
    .clk       (clk),
    .rst       (rst),
    .load      (nxt_load),
    .load_data (core_block),
    .swap      (cur_swap),
    .swap_data (cur_words),
    .sel       ('0),
    .words     (nxt_words),
    .sel_byte_c(nxt_byte0_c)
  );

  // Next-state, datapath and request logic.
  always_comb begin
    logic xfer;
    logic got;
    logic issue;

    state_d      = state_q;
    core_start_d = 1'b0;
    core_ctr_d   = core_ctr_q;
    ks_byte_d    = ks_byte_q;
    ks_valid_d   = ks_valid_q;
    ks_last_d    = ks_last_q;
    done_d       = 1'b0;
    err_wrap_d   = err_wrap_q;
    rem_d        = rem_q;
    idx_d        = idx_q;
    pend_d       = pend_q;
    next_valid_d = next_valid_q;
    cur_load     = 1'b0;
    cur_swap     = 1'b0;
    nxt_load     = 1'b0;
    issue        = 1'b0;

    xfer = ks_valid_q && ks_ready;
    // Only a response to our own outstanding request counts.
    got  = pend_q && core_done;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          err_wrap_d   = 1'b0;
          next_valid_d = 1'b0;
          pend_d       = 1'b0;
          if (msg_len == '0) begin
            state_d = ST_FIN;
            done_d  = 1'b1;
          end else begin
            rem_d        = msg_len;
            core_ctr_d   = init_ctr;
            core_start_d = 1'b1;
            pend_d       = 1'b1;
            state_d      = ST_FETCH;
          end
        end
      end

      ST_FETCH: begin
        if (got) begin
          cur_load   = 1'b1;
          pend_d     = 1'b0;
          idx_d      = '0;
          ks_byte_d  = block_byte(core_block, '0);
          ks_valid_d = 1'b1;
          ks_last_d  = (rem_q == LEN_W'(1));
          state_d    = ST_STREAM;
          issue      = (rem_q > LEN_W'(BLOCK_BYTES));
        end
      end

      ST_STREAM: begin
        // Prefetch landing while the current block is still mid-stream.
        if (got && !(xfer && idx_q == LAST_IDX)) begin
          nxt_load     = 1'b1;
          next_valid_d = 1'b1;
          pend_d       = 1'b0;
        end
        if (xfer) begin
          rem_d     = rem_q - 1'b1;
          idx_d     = IDX_W'(idx_q + 1'b1);
          ks_last_d = (rem_q == LEN_W'(2));
          ks_byte_d = cur_byte_c;
          if (rem_q == LEN_W'(1)) begin
            ks_valid_d = 1'b0;
            ks_last_d  = 1'b0;
            done_d     = 1'b1;
            state_d    = ST_FIN;
          end else if (idx_q == LAST_IDX) begin
            if (next_valid_q) begin
              cur_swap     = 1'b1;
              next_valid_d = 1'b0;
              ks_byte_d    = nxt_byte0_c;
              issue        = (rem_q > LEN_W'(BLOCK_BYTES + 1));
            end else if (got) begin
              // Prefetch arrives exactly at the boundary: straight into current.
              cur_load  = 1'b1;
              pend_d    = 1'b0;
              ks_byte_d = block_byte(core_block, '0);
              issue     = (rem_q > LEN_W'(BLOCK_BYTES + 1));
            end else if (pend_q) begin
              ks_valid_d = 1'b0;
              ks_last_d  = 1'b0;
              state_d    = ST_FETCH;
            end else begin
              // No further block could be requested (counter exhausted).
              ks_valid_d = 1'b0;
              ks_last_d  = 1'b0;
              done_d     = 1'b1;
              state_d    = ST_FIN;
            end
          end
        end
      end

      ST_FIN: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Request the following block unless its counter would wrap.
    if (issue) begin
      if (core_ctr_q == '1) begin
        err_wrap_d = 1'b1;
      end else begin
        core_start_d = 1'b1;
        core_ctr_d   = core_ctr_q + 32'd1;
        pend_d       = 1'b1;
      end
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      core_start_q <= 1'b0;
      core_ctr_q   <= '0;
      ks_byte_q    <= '0;
      ks_valid_q   <= 1'b0;
      ks_last_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_wrap_q   <= 1'b0;
      rem_q        <= '0;
      idx_q        <= '0;
      pend_q       <= 1'b0;
      next_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      core_start_q <= core_start_d;
      core_ctr_q   <= core_ctr_d;
      ks_byte_q    <= ks_byte_d;
      ks_valid_q   <= ks_valid_d;
      ks_last_q    <= ks_last_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_wrap_q   <= err_wrap_d;
      rem_q        <= rem_d;
      idx_q        <= idx_d;
      pend_q       <= pend_d;
      next_valid_q <= next_valid_d;
    end
  end

  assign core_start = core_start_q;
  assign core_ctr   = core_ctr_q;
  assign ks_byte    = ks_byte_q;
  assign ks_valid   = ks_valid_q;
  assign ks_last    = ks_last_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err_wrap   = err_wrap_q;

endmodule
